// File: rtl/enc_pack_scheduler_pkg.sv
// rtl/enc_pack_scheduler_pkg.sv - shared encoder constants, pack scheduler types and mask helper
// Contents: NUM_FEATURES / PACK_SIZE / NUM_PACKS / BIND_LAT, pack_idx_t,
//           sched_state_t, last_pack_mask()
package enc_pack_scheduler_pkg;

    localparam int NUM_FEATURES = 617;
    localparam int PACK_SIZE    = 10;
    localparam int NUM_PACKS    = 62;
    localparam int BIND_LAT     = 1;
    localparam int PACK_IDX_W   = $clog2(NUM_PACKS);

    typedef logic [PACK_IDX_W-1:0] pack_idx_t;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        BIND,
        EMIT,
        DONE
    } sched_state_t;

    // Valid-binder mask of the final pack: the low R bits, where R is the
    // number of features left over after all full packs (1..pack_size).
    function automatic logic [31:0] last_pack_mask(input int num_features,
                                                   input int pack_size,
                                                   input int num_packs);
        int rem;
        rem = num_features - (num_packs - 1) * pack_size;
        if (rem >= 32) begin
            return '1;
        end
        return (32'd1 << rem) - 32'd1;
    endfunction

endpackage

// File: rtl/enc_pack_scheduler.sv
// rtl/enc_pack_scheduler.sv - sequences level fetch, bind start and token hand-off for every binder pack
// Ports: clk, nrst (async active-low), start, abort;
//        lvl_rd_req/lvl_rd_pack/lvl_rd_ack  level-HV fetch handshake;
//        pack_start                          one-hot start_encoding per pack;
//        out_valid/out_ready/out_pack/out_mask/out_last  token to the bundler;
//        busy, done                          status
module enc_pack_scheduler #(
    parameter int NUM_FEATURES = enc_pack_scheduler_pkg::NUM_FEATURES,
    parameter int PACK_SIZE    = enc_pack_scheduler_pkg::PACK_SIZE,
    parameter int NUM_PACKS    = enc_pack_scheduler_pkg::NUM_PACKS,
    parameter int BIND_LAT     = enc_pack_scheduler_pkg::BIND_LAT
) (
    input  logic                         clk,
    input  logic                         nrst,
    input  logic                         start,
    input  logic                         abort,
    output logic                         lvl_rd_req,
    output logic [$clog2(NUM_PACKS)-1:0] lvl_rd_pack,
    input  logic                         lvl_rd_ack,
    output logic [NUM_PACKS-1:0]         pack_start,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [$clog2(NUM_PACKS)-1:0] out_pack,
    output logic [PACK_SIZE-1:0]         out_mask,
    output logic                         out_last,
    output logic                         busy,
    output logic                         done
);
    import enc_pack_scheduler_pkg::*;

    localparam int IDX_W = $clog2(NUM_PACKS);
    localparam int CNT_W = (BIND_LAT > 0) ? $clog2(BIND_LAT + 1) : 1;

    localparam logic [PACK_SIZE-1:0] FULL_MASK = '1;
    localparam logic [PACK_SIZE-1:0] LAST_MASK =
        PACK_SIZE'(last_pack_mask(NUM_FEATURES, PACK_SIZE, NUM_PACKS));
    localparam logic [IDX_W-1:0]     LAST_IDX  = IDX_W'(NUM_PACKS - 1);
    localparam logic [CNT_W-1:0]     CNT_LOAD  = CNT_W'(BIND_LAT);

    // Pack count must cover every feature with the last pack non-empty.
    if (!((NUM_PACKS * PACK_SIZE >= NUM_FEATURES) &&
          (NUM_FEATURES > (NUM_PACKS - 1) * PACK_SIZE))) begin : g_geometry_check
        $error("enc_pack_scheduler: NUM_PACKS does not equal ceil(NUM_FEATURES/PACK_SIZE)");
    end

    sched_state_t     state;
    sched_state_t     state_next;
    logic [IDX_W-1:0] pack_idx;
    logic [CNT_W-1:0] bind_cnt;
    logic             is_last;

    assign is_last = (pack_idx == LAST_IDX);

    // State register plus pack index / bind counter datapath.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state    <= IDLE;
            pack_idx <= '0;
            bind_cnt <= '0;
        end else begin
            state <= state_next;
            if (abort) begin
                pack_idx <= '0;
                bind_cnt <= '0;
            end else begin
                case (state)
                    IDLE:  if (start) pack_idx <= '0;
                    FETCH: if (lvl_rd_ack) bind_cnt <= CNT_LOAD;
                    BIND:  if (bind_cnt != '0) bind_cnt <= bind_cnt - CNT_W'(1);
                    // The index only advances below LAST_IDX, so it never wraps.
                    EMIT:  if (out_ready && !is_last) pack_idx <= pack_idx + IDX_W'(1);
                    DONE:  pack_idx <= '0;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        state_next = state;
        if (abort) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (start) state_next = FETCH;
                FETCH:   if (lvl_rd_ack) state_next = BIND;
                BIND:    if (bind_cnt == '0) state_next = EMIT;
                EMIT:    if (out_ready) state_next = is_last ? DONE : FETCH;
                DONE:    state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // All outputs decode from registered state, so an async reset clears
    // them immediately.
    always_comb begin
        lvl_rd_req  = 1'b0;
        lvl_rd_pack = '0;
        pack_start  = '0;
        out_valid   = 1'b0;
        out_pack    = '0;
        out_mask    = '0;
        out_last    = 1'b0;
        busy        = (state != IDLE);
        done        = (state == DONE);
        case (state)
            FETCH: begin
                lvl_rd_req  = 1'b1;
                lvl_rd_pack = pack_idx;
            end
            BIND: begin
                // Counter still holds its load value only in the first BIND cycle.
                if (bind_cnt == CNT_LOAD) begin
                    pack_start = NUM_PACKS'(1) << pack_idx;
                end
            end
            EMIT: begin
                out_valid = 1'b1;
                out_pack  = pack_idx;
                out_last  = is_last;
                out_mask  = is_last ? LAST_MASK : FULL_MASK;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_enc_pack_scheduler.sv
// tb/tb_enc_pack_scheduler.sv - self-checking bench for enc_pack_scheduler
module tb_enc_pack_scheduler;
    import enc_pack_scheduler_pkg::*;

    localparam int NF    = NUM_FEATURES;
    localparam int NF2   = 620;
    localparam int PS    = PACK_SIZE;
    localparam int NP    = NUM_PACKS;
    localparam int BL    = BIND_LAT;
    localparam int IW    = $clog2(NUM_PACKS);
    localparam int NEVER = 32'h7fffffff;

    logic          clk = 1'b0;
    logic          nrst = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          lvl_rd_ack = 1'b0;
    logic          out_ready = 1'b0;
    logic          lvl_rd_req;
    logic [IW-1:0] lvl_rd_pack;
    logic [NP-1:0] pack_start;
    logic          out_valid;
    logic [IW-1:0] out_pack;
    logic [PS-1:0] out_mask;
    logic          out_last;
    logic          busy;
    logic          done;

    logic          u2_lvl_rd_req;
    logic [IW-1:0] u2_lvl_rd_pack;
    logic [NP-1:0] u2_pack_start;
    logic          u2_out_valid;
    logic [IW-1:0] u2_out_pack;
    logic [PS-1:0] u2_out_mask;
    logic          u2_out_last;
    logic          u2_busy;
    logic          u2_done;

    enc_pack_scheduler dut (
        .clk(clk), .nrst(nrst), .start(start), .abort(abort),
        .lvl_rd_req(lvl_rd_req), .lvl_rd_pack(lvl_rd_pack), .lvl_rd_ack(lvl_rd_ack),
        .pack_start(pack_start), .out_valid(out_valid), .out_ready(out_ready),
        .out_pack(out_pack), .out_mask(out_mask), .out_last(out_last),
        .busy(busy), .done(done)
    );

    enc_pack_scheduler #(.NUM_FEATURES(NF2)) u2 (
        .clk(clk), .nrst(nrst), .start(start), .abort(abort),
        .lvl_rd_req(u2_lvl_rd_req), .lvl_rd_pack(u2_lvl_rd_pack), .lvl_rd_ack(lvl_rd_ack),
        .pack_start(u2_pack_start), .out_valid(u2_out_valid), .out_ready(out_ready),
        .out_pack(u2_out_pack), .out_mask(u2_out_mask), .out_last(u2_out_last),
        .busy(u2_busy), .done(u2_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    // Reference model: time-stamped milestones of the current pack.
    bit m_run = 1'b0;
    bit m_fetch = 1'b0;
    int m_pack = 0;
    int m_bind_at = -1;
    int m_valid_at = NEVER;
    int m_done_at = -1;

    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            m_run = 1'b0; m_fetch = 1'b0; m_pack = 0;
            m_bind_at = -1; m_valid_at = NEVER; m_done_at = -1;
        end else if (abort) begin
            m_run = 1'b0; m_fetch = 1'b0; m_pack = 0;
            m_bind_at = -1; m_valid_at = NEVER; m_done_at = -1;
        end else if (m_done_at == cyc) begin
            m_run = 1'b0;
            m_done_at = -1;
        end else if (!m_run) begin
            if (start) begin
                m_run = 1'b1; m_pack = 0; m_fetch = 1'b1;
            end
        end else if (m_fetch) begin
            if (lvl_rd_ack) begin
                m_fetch = 1'b0;
                m_bind_at = cyc + 1;
                m_valid_at = cyc + 1 + BL + 1;
            end
        end else if (cyc >= m_valid_at && out_ready) begin
            m_valid_at = NEVER;
            if (m_pack == NP - 1) begin
                m_done_at = cyc + 1;
            end else begin
                m_pack = m_pack + 1;
                m_fetch = 1'b1;
            end
        end
    end

    function automatic logic [PS-1:0] exp_mask(input int nf, input int p);
        if (p == NP - 1) return PS'((1 << (nf - (NP - 1) * PS)) - 1);
        return '1;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic compare();
        logic [NP-1:0] oh;
        bit e_valid;
        oh = '0;
        if (m_bind_at == cyc) oh[m_pack] = 1'b1;
        e_valid = (cyc >= m_valid_at);
        chk("lvl_rd_req", 64'(lvl_rd_req), 64'(m_fetch));
        if (m_fetch) chk("lvl_rd_pack", 64'(lvl_rd_pack), 64'(m_pack));
        chk("pack_start", 64'(pack_start), 64'(oh));
        chk("out_valid", 64'(out_valid), 64'(e_valid));
        if (e_valid) begin
            chk("out_pack", 64'(out_pack), 64'(m_pack));
            chk("out_mask", 64'(out_mask), 64'(exp_mask(NF, m_pack)));
            chk("out_last", 64'(out_last), 64'(m_pack == NP - 1));
            chk("u2_out_mask", 64'(u2_out_mask), 64'(exp_mask(NF2, m_pack)));
        end
        chk("busy", 64'(busy), 64'(m_run));
        chk("done", 64'(done), 64'(m_done_at == cyc));
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        compare();
    endtask

    int            ps_cyc[NP];
    logic [PS-1:0] tok_mask[NP];
    bit            tok_last[NP];
    int            tok_cnt, done_cnt, done_cyc, idle_cyc;

    // mode: 0 nominal, 1 backpressure pack 5, 2 slow ack pack 0,
    //       3 start while busy, 4 abort in BIND of 20, 5 reset in EMIT of 30, 6 random
    task automatic run(input int mode, output int s0);
        int held, late;
        bit fired, ok;
        held = 0; late = 0; fired = 1'b0; ok = 1'b0;
        for (int k = 0; k < NP; k++) begin
            ps_cyc[k] = -1; tok_mask[k] = '0; tok_last[k] = 1'b0;
        end
        tok_cnt = 0; done_cnt = 0; done_cyc = -1; idle_cyc = -1;
        start = 1'b1; lvl_rd_ack = 1'b1; out_ready = 1'b1;
        s0 = cyc;
        for (int i = 0; i < 3000; i++) begin
            tick();
            start = 1'b0; abort = 1'b0; lvl_rd_ack = 1'b1; out_ready = 1'b1;
            case (mode)
                1: if (out_valid && out_pack == 5 && held < 7) begin out_ready = 1'b0; held++; end
                2: if (lvl_rd_req && lvl_rd_pack == 0 && late < 3) begin lvl_rd_ack = 1'b0; late++; end
                3: if (out_valid && (out_pack == 3 || out_pack == 40)) start = 1'b1;
                4: if (pack_start[20] && !fired) begin abort = 1'b1; fired = 1'b1; end
                5: if (out_valid && out_pack == 30 && !fired) begin
                    fired = 1'b1;
                    out_ready = 1'b0;
                    #2 nrst = 1'b0;
                    #1;
                    chk("reset_pack_start", 64'(pack_start), 64'd0);
                    chk("reset_ctrl", 64'({lvl_rd_req, lvl_rd_pack, out_valid, out_pack,
                                           out_mask, out_last, busy, done}), 64'd0);
                    compare();
                end
                6: begin
                    lvl_rd_ack = ($urandom_range(0, 2) != 0);
                    out_ready  = ($urandom_range(0, 2) != 0);
                end
                default: ;
            endcase
            for (int k = 0; k < NP; k++)
                if (pack_start[k] && ps_cyc[k] < 0) ps_cyc[k] = cyc;
            if (out_valid && out_ready) begin
                tok_cnt++;
                tok_mask[out_pack] = out_mask;
                tok_last[out_pack] = out_last;
            end
            if (done) begin done_cnt++; done_cyc = cyc; end
            if (!busy) begin idle_cyc = cyc; ok = 1'b1; break; end
        end
        chk("run_completed", 64'(ok), 64'd1);
    endtask

    int s0;

    initial begin
        nrst = 1'b0;
        repeat (3) tick();
        chk("reset_pack_start", 64'(pack_start), 64'd0);
        chk("reset_ctrl", 64'({lvl_rd_req, lvl_rd_pack, out_valid, out_pack,
                               out_mask, out_last, busy, done}), 64'd0);
        nrst = 1'b1;
        repeat (3) tick();

        // Nominal run, ack/ready always high.
        run(0, s0);
        for (int k = 0; k < NP; k++) chk("nom_pack_start_cycle", 64'(ps_cyc[k] - s0), 64'(2 + 4 * k));
        chk("nom_tokens", 64'(tok_cnt), 64'd62);
        chk("nom_done_cnt", 64'(done_cnt), 64'd1);
        chk("nom_done_cycle", 64'(done_cyc - s0), 64'd249);
        chk("nom_idle_cycle", 64'(idle_cyc - s0), 64'd250);
        chk("nom_mask_0", 64'(tok_mask[0]), 64'h3FF);
        chk("nom_mask_60", 64'(tok_mask[60]), 64'h3FF);
        chk("nom_mask_61", 64'(tok_mask[61]), 64'h07F);
        chk("nom_last_60", 64'(tok_last[60]), 64'd0);
        chk("nom_last_61", 64'(tok_last[61]), 64'd1);
        repeat (3) tick();

        run(1, s0);
        chk("bp_pack_start_5", 64'(ps_cyc[5] - s0), 64'd22);
        chk("bp_pack_start_6", 64'(ps_cyc[6] - s0), 64'd33);
        chk("bp_done_cycle", 64'(done_cyc - s0), 64'd256);
        chk("bp_tokens", 64'(tok_cnt), 64'd62);
        repeat (3) tick();

        run(2, s0);
        chk("slow_pack_start_0", 64'(ps_cyc[0] - s0), 64'd5);
        chk("slow_done_cycle", 64'(done_cyc - s0), 64'd252);
        repeat (3) tick();

        run(3, s0);
        chk("sbusy_tokens", 64'(tok_cnt), 64'd62);
        chk("sbusy_done_cnt", 64'(done_cnt), 64'd1);
        chk("sbusy_done_cycle", 64'(done_cyc - s0), 64'd249);
        repeat (3) tick();

        run(4, s0);
        chk("abort_pack_start_20", 64'(ps_cyc[20] - s0), 64'd82);
        chk("abort_tokens", 64'(tok_cnt), 64'd20);
        chk("abort_done_cnt", 64'(done_cnt), 64'd0);
        chk("abort_idle_cycle", 64'(idle_cyc - s0), 64'd83);
        repeat (5) tick();
        chk("abort_stays_idle", 64'(busy), 64'd0);
        run(0, s0);
        chk("post_abort_pack_start_0", 64'(ps_cyc[0] - s0), 64'd2);
        chk("post_abort_tokens", 64'(tok_cnt), 64'd62);
        chk("post_abort_done_cnt", 64'(done_cnt), 64'd1);
        repeat (3) tick();

        run(5, s0);
        chk("rst_tokens", 64'(tok_cnt), 64'd30);
        chk("rst_done_cnt", 64'(done_cnt), 64'd0);
        tick();
        nrst = 1'b1;
        repeat (2) tick();
        run(0, s0);
        chk("post_rst_tokens", 64'(tok_cnt), 64'd62);
        chk("post_rst_done_cycle", 64'(done_cyc - s0), 64'd249);
        repeat (3) tick();

        // start and abort together in IDLE: stay idle.
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        chk("start_abort_idle", 64'(busy), 64'd0);
        repeat (2) tick();

        for (int r = 0; r < 2; r++) begin
            run(6, s0);
            chk("rand_tokens", 64'(tok_cnt), 64'd62);
            chk("rand_done_cnt", 64'(done_cnt), 64'd1);
            chk("rand_last_mask", 64'(tok_mask[61]), 64'h07F);
            repeat (3) tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
